// File: rtl/load_store_unit_if.sv
// Shared memop type plus the request/response and data-bus bundle of the load/store unit.
// The slave modport is the LSU view; the master modport is the surrounding pipeline and memory.
package lsu_pkg;
  typedef enum logic [3:0] {
    memop_nop,
    l_byte,
    l_hword,
    l_word,
    l_ubyte,
    l_uhword,
    s_byte,
    s_hword,
    s_word
  } rv32_memop;
endpackage

interface load_store_unit_if;
  import lsu_pkg::*;

  logic        i_valid;
  logic        o_ready;
  rv32_memop   i_memop;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_valid;
  logic [31:0] o_rdata;
  logic        o_misaligned;
  logic        o_fault;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  modport slave (
    input  i_valid, i_memop, i_addr, i_wdata, i_mem_ack, i_mem_rdata,
    output o_ready, o_valid, o_rdata, o_misaligned, o_fault,
           o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata
  );

  modport master (
    output i_valid, i_memop, i_addr, i_wdata, i_mem_ack, i_mem_rdata,
    input  o_ready, o_valid, o_rdata, o_misaligned, o_fault,
           o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: one req/ack data-bus transaction per decoded memop, with lane steering
// and load extension. Define LSU_BUS_TIMEOUT_EN to abort REQ after TIMEOUT_CYCLES with o_fault.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic            i_clk,
  input logic            i_rst,
  load_store_unit_if.slave lsu
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e      state_q, state_d;
  rv32_memop   memop_q, memop_d;
  logic [1:0]  off_q, off_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;
  logic        fault_q, fault_d;
  logic        timeout;

  function automatic logic [3:0] lane_be(rv32_memop op, logic [1:0] off);
    unique case (op)
      l_byte, l_ubyte, s_byte:    return 4'b0001 << off;
      l_hword, l_uhword, s_hword: return 4'b0011 << off;
      l_word, s_word:             return 4'b1111;
      default:                    return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(rv32_memop op, logic [31:0] w);
    unique case (op)
      s_byte:  return {4{w[7:0]}};
      s_hword: return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  function automatic logic is_misaligned(rv32_memop op, logic [1:0] off);
    unique case (op)
      l_hword, l_uhword, s_hword: return off[0];
      l_word, s_word:             return |off;
      default:                    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(rv32_memop op, logic [1:0] off, logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    unique case (op)
      l_byte:   return {{24{b[7]}}, b};
      l_ubyte:  return {24'b0, b};
      l_hword:  return {{16{h[15]}}, h};
      l_uhword: return {16'b0, h};
      l_word:   return w;
      default:  return 32'b0;
    endcase
  endfunction

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int CntRaw = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CntW   = (CntRaw < 8) ? 8 : ((CntRaw > 32) ? 32 : CntRaw);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Counts elapsed REQ cycles; zero whenever the unit is outside REQ.
  always_comb begin
    cnt_d = (state_q == REQ) ? cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  // NOTE: every _d is given its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    memop_d = memop_q;
    off_d   = off_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    fault_d = fault_q;

    unique case (state_q)
      IDLE: begin
        if (lsu.i_valid) begin
          memop_d = lsu.i_memop;
          off_d   = lsu.i_addr[1:0];
          we_d    = lsu.i_memop inside {s_byte, s_hword, s_word};
          addr_d  = {lsu.i_addr[31:2], 2'b00};
          be_d    = lane_be(lsu.i_memop, lsu.i_addr[1:0]);
          wdata_d = lane_wdata(lsu.i_memop, lsu.i_wdata);
          rdata_d = 32'b0;
          mis_d   = is_misaligned(lsu.i_memop, lsu.i_addr[1:0]);
          fault_d = 1'b0;
          state_d = (lsu.i_memop == memop_nop || mis_d) ? RESP : REQ;
        end
      end
      REQ: begin
        // Ack is checked first so a same-cycle ack beats the timeout.
        if (lsu.i_mem_ack) begin
          rdata_d = load_ext(memop_q, off_q, lsu.i_mem_rdata);
          state_d = RESP;
        end else if (timeout) begin
          fault_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      memop_q <= memop_nop;
      off_q   <= 2'b00;
      we_q    <= 1'b0;
      addr_q  <= 32'b0;
      be_q    <= 4'b0;
      wdata_q <= 32'b0;
      rdata_q <= 32'b0;
      mis_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      memop_q <= memop_d;
      off_q   <= off_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      fault_q <= fault_d;
    end
  end

  // Request is decoded from state so an asynchronous reset drops it without a clock edge.
  assign lsu.o_ready      = (state_q == IDLE);
  assign lsu.o_mem_req    = (state_q == REQ);
  assign lsu.o_valid      = (state_q == RESP);
  assign lsu.o_misaligned = lsu.o_valid & mis_q;
  assign lsu.o_fault      = lsu.o_valid & fault_q;
  assign lsu.o_rdata      = rdata_q;
  assign lsu.o_mem_we     = we_q;
  assign lsu.o_mem_addr   = addr_q;
  assign lsu.o_mem_be     = be_q;
  assign lsu.o_mem_wdata  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized memops, compared
// every cycle against a transaction-level model of the expected bus and completion behaviour.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .lsu  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  function automatic int size_of(rv32_memop op);
    case (op)
      l_byte, l_ubyte, s_byte:    return 1;
      l_hword, l_uhword, s_hword: return 2;
      l_word, s_word:             return 4;
      default:                    return 0;
    endcase
  endfunction

  function automatic bit is_store(rv32_memop op);
    return op == s_byte || op == s_hword || op == s_word;
  endfunction

  function automatic bit model_mis(rv32_memop op, logic [31:0] addr);
    int sz = size_of(op);
    return sz > 1 && (int'(addr[1:0]) % sz) != 0;
  endfunction

  function automatic logic [3:0] model_be(rv32_memop op, logic [31:0] addr);
    int v = ((1 << size_of(op)) - 1) << int'(addr[1:0]);
    return v[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(rv32_memop op, logic [31:0] w);
    case (size_of(op))
      1:       return (w & 32'hFF) * 32'h0101_0101;
      2:       return (w & 32'hFFFF) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_load(rv32_memop op, logic [31:0] addr, logic [31:0] word);
    int     sz = size_of(op);
    longint v;
    if (sz == 4) return word;
    v = (longint'(word) >> (8 * int'(addr[1:0]))) & ((64'd1 << (8 * sz)) - 1);
    if ((op == l_byte || op == l_hword) && v >= (64'd1 << (8 * sz - 1)))
      v = v - (64'd1 << (8 * sz));
    return v[31:0];
  endfunction

  // ---------------- expected outputs for the current cycle ----------------
  bit          chk_en = 1'b0;
  logic        exp_ready, exp_req, exp_valid, exp_we, exp_mis, exp_fault;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_be;

  int          req_total = 0, valid_total = 0;
  logic [31:0] cap_addr, cap_wdata, cap_rdata;
  logic [3:0]  cap_be;
  logic        cap_we, cap_mis, cap_fault;

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", 32'(bus.o_ready), 32'(exp_ready));
      check("mem_req", 32'(bus.o_mem_req), 32'(exp_req));
      check("valid", 32'(bus.o_valid), 32'(exp_valid));
      if (exp_req) begin
        check("mem_we", 32'(bus.o_mem_we), 32'(exp_we));
        check("mem_addr", bus.o_mem_addr, exp_addr);
        check("mem_be", 32'(bus.o_mem_be), 32'(exp_be));
        if (exp_we) check("mem_wdata", bus.o_mem_wdata, exp_wdata);
      end
      if (exp_valid) begin
        check("rdata", bus.o_rdata, exp_rdata);
        check("misaligned", 32'(bus.o_misaligned), 32'(exp_mis));
        check("fault", 32'(bus.o_fault), 32'(exp_fault));
      end
      if (bus.o_mem_req) begin
        req_total++;
        cap_addr  = bus.o_mem_addr;
        cap_be    = bus.o_mem_be;
        cap_we    = bus.o_mem_we;
        cap_wdata = bus.o_mem_wdata;
      end
      if (bus.o_valid) begin
        valid_total++;
        cap_rdata = bus.o_rdata;
        cap_mis   = bus.o_misaligned;
        cap_fault = bus.o_fault;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_idle();
    exp_ready = 1'b1;
    exp_req   = 1'b0;
    exp_valid = 1'b0;
  endtask

  // Garbage on the request side while the unit is busy; it must not be accepted.
  task automatic junk();
    bus.i_valid = 1'($urandom_range(0, 1));
    bus.i_memop = rv32_memop'(4'($urandom_range(0, 8)));
    bus.i_addr  = $urandom();
    bus.i_wdata = $urandom();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    set_idle();
    for (int i = 0; i < n; i++) begin
      bus.i_valid     = 1'b0;
      bus.i_mem_ack   = 1'($urandom_range(0, 1));
      bus.i_mem_rdata = $urandom();
      step();
    end
    bus.i_mem_ack = 1'b0;
  endtask

  // waits < 0 means the bus never acknowledges.
  task automatic run_op(input rv32_memop op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] word, input int waits);
    bit mis    = model_mis(op, addr);
    bit bus_op = (op != memop_nop) && !mis;
    bit tmo    = (waits < 0);
    int n_req  = tmo ? TMO : waits + 1;

    set_idle();
    bus.i_valid     = 1'b1;
    bus.i_memop     = op;
    bus.i_addr      = addr;
    bus.i_wdata     = wdata;
    bus.i_mem_ack   = 1'($urandom_range(0, 1));
    bus.i_mem_rdata = $urandom();
    step();
    exp_ready = 1'b0;
    if (bus_op) begin
      exp_req   = 1'b1;
      exp_we    = is_store(op);
      exp_addr  = addr & ~32'h3;
      exp_be    = model_be(op, addr);
      exp_wdata = model_wdata(op, wdata);
      for (int k = 0; k < n_req; k++) begin
        junk();
        bus.i_mem_ack   = !tmo && (k == n_req - 1);
        bus.i_mem_rdata = bus.i_mem_ack ? word : $urandom();
        step();
      end
      exp_req   = 1'b0;
      exp_rdata = (tmo || is_store(op)) ? 32'h0 : model_load(op, addr, word);
      exp_fault = tmo;
      exp_mis   = 1'b0;
    end else begin
      exp_rdata = 32'h0;
      exp_fault = 1'b0;
      exp_mis   = mis;
    end
    exp_valid = 1'b1;
    junk();
    bus.i_mem_ack   = 1'($urandom_range(0, 1));
    bus.i_mem_rdata = $urandom();
    step();
    set_idle();
    bus.i_valid   = 1'b0;
    bus.i_mem_ack = 1'b0;
  endtask

  initial begin
    int r0, v0;

    rst             = 1'b1;
    bus.i_valid     = 1'b0;
    bus.i_memop     = memop_nop;
    bus.i_addr      = 32'h0;
    bus.i_wdata     = 32'h0;
    bus.i_mem_ack   = 1'b0;
    bus.i_mem_rdata = 32'h0;
    set_idle();
    #12;
    check("rst_ready", 32'(bus.o_ready), 32'h1);
    check("rst_req", 32'(bus.o_mem_req), 32'h0);
    check("rst_valid", 32'(bus.o_valid), 32'h0);
    check("rst_we", 32'(bus.o_mem_we), 32'h0);
    check("rst_addr", bus.o_mem_addr, 32'h0);
    check("rst_be", 32'(bus.o_mem_be), 32'h0);
    check("rst_wdata", bus.o_mem_wdata, 32'h0);
    check("rst_rdata", bus.o_rdata, 32'h0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    idle_cycles(2);

    // Signed byte load from the top lane, ack in the first REQ cycle.
    r0 = req_total; v0 = valid_total;
    run_op(l_byte, 32'h1003, 32'h0, 32'h80FF_1234, 0);
    check("lb_be", 32'(cap_be), 32'h8);
    check("lb_rdata", cap_rdata, 32'hFFFF_FF80);
    check("lb_req_cycles", 32'(req_total - r0), 32'd1);
    check("lb_valid_cnt", 32'(valid_total - v0), 32'd1);

`ifndef LSU_BUS_TIMEOUT_EN
    // Unsigned halfword load with five wait cycles.
    r0 = req_total;
    run_op(l_uhword, 32'h2002, 32'h0, 32'hBEEF_0000, 5);
    check("lhu_req_cycles", 32'(req_total - r0), 32'd6);
    check("lhu_addr", cap_addr, 32'h2000);
    check("lhu_rdata", cap_rdata, 32'h0000_BEEF);
`endif

    // Halfword store, lane replication.
    run_op(s_hword, 32'h10, 32'h1234_ABCD, 32'hDEAD_BEEF, 1);
    check("sh_we", 32'(cap_we), 32'h1);
    check("sh_be", 32'(cap_be), 32'h3);
    check("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    check("sh_rdata", cap_rdata, 32'h0);

    // Misaligned word load and nop never reach the bus.
    r0 = req_total; v0 = valid_total;
    run_op(l_word, 32'h6, 32'h0, 32'h0, 0);
    check("lw_mis_req", 32'(req_total - r0), 32'd0);
    check("lw_mis_flag", 32'(cap_mis), 32'h1);
    check("lw_mis_rdata", cap_rdata, 32'h0);
    r0 = req_total;
    run_op(memop_nop, 32'h0, 32'h0, 32'h0, 0);
    check("nop_req", 32'(req_total - r0), 32'd0);
    check("nop_valid_cnt", 32'(valid_total - v0), 32'd2);

    // Reset mid-REQ: request falls without a clock edge, no completion follows.
    bus.i_valid = 1'b1;
    bus.i_memop = l_word;
    bus.i_addr  = 32'h80;
    step();
    bus.i_valid = 1'b0;
    exp_ready   = 1'b0;
    exp_req     = 1'b1;
    exp_we      = 1'b0;
    exp_addr    = 32'h80;
    exp_be      = 4'hF;
    step();
    v0 = valid_total;
    #2;
    rst = 1'b1;
    set_idle();
    #1;
    check("arst_req", 32'(bus.o_mem_req), 32'h0);
    check("arst_ready", 32'(bus.o_ready), 32'h1);
    step();
    rst = 1'b0;
    idle_cycles(3);
    check("arst_no_valid", 32'(valid_total - v0), 32'd0);
    run_op(s_word, 32'h40, 32'hCAFE_F00D, 32'h0, 0);
    check("post_rst_valid", 32'(valid_total - v0), 32'd1);
    check("post_rst_addr", cap_addr, 32'h40);
    check("post_rst_wdata", cap_wdata, 32'hCAFE_F00D);

`ifdef LSU_BUS_TIMEOUT_EN
    r0 = req_total;
    run_op(l_word, 32'h100, 32'h0, 32'h0, -1);
    check("tmo_req_cycles", 32'(req_total - r0), 32'(TMO));
    check("tmo_fault", 32'(cap_fault), 32'h1);
    check("tmo_rdata", cap_rdata, 32'h0);
    // Ack on the final permitted cycle still completes normally.
    run_op(l_ubyte, 32'h101, 32'h0, 32'h0000_A500, TMO - 1);
    check("tmo_edge_fault", 32'(cap_fault), 32'h0);
    check("tmo_edge_rdata", cap_rdata, 32'h0000_00A5);
`endif

    // Randomized mix: all memops, any offset, variable wait states and idle gaps.
    for (int n = 0; n < 200; n++) begin
      rv32_memop   op;
      logic [31:0] a;
      op = rv32_memop'(4'($urandom_range(0, 8)));
      a  = $urandom();
      run_op(op, a, $urandom(), $urandom(), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) != 0) idle_cycles(int'($urandom_range(0, 2)));
    end

    idle_cycles(2);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage directly downstream of the memop decoder. It consumes a decoded rv32_memop, an effective address and store data, then runs one data-bus transaction with a req/ack handshake. It generates byte enables and lane-aligned write data, and returns sign- or zero-extended load data. Misaligned accesses are detected and reported without touching the bus.

Parameters:
TIMEOUT_CYCLES, 255, maximum REQ-state cycles before abort (used only with LSU_BUS_TIMEOUT_EN).

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  reset, asynchronous, active-high
i_valid  input  1  request valid
o_ready  output  1  unit can accept a request
i_memop  input  rv32_memop  decoded operation (memop_nop, l_byte/hword/word/ubyte/uhword, s_byte/hword/word)
i_addr  input  32  effective byte address
i_wdata  input  32  store data, right-justified
o_valid  output  1  one-cycle completion pulse
o_rdata  output  32  extended load result; 0 for stores, nop and misaligned
o_misaligned  output  1  qualifies o_valid: access misaligned, not performed
o_fault  output  1  qualifies o_valid: bus timeout (tied 0 without macro)
o_mem_req  output  1  bus request
o_mem_we  output  1  1 = write
o_mem_addr  output  32  word address: {addr[31:2],2'b00}
o_mem_be  output  4  byte enables
o_mem_wdata  output  32  lane-replicated store data
i_mem_ack  input  1  bus acknowledge; read data valid in same cycle
i_mem_rdata  input  32  bus read word

Behaviour:
- Reset is asynchronous. Asserting i_rst forces state IDLE and clears all registers. Output values during and after reset: o_ready=1; o_valid, o_misaligned, o_fault, o_mem_req, o_mem_we = 0; o_mem_addr, o_mem_be, o_mem_wdata, o_rdata = 0.
- Reset during REQ abandons the transaction. o_mem_req drops immediately, not on a clock edge.
- FSM has three states: IDLE, REQ, RESP. o_ready = (state==IDLE).
- A request is accepted on a cycle with i_valid & o_ready. memop, addr[1:0] and the bus fields are registered on that edge.
- Misalignment rule: a halfword access with addr[0]=1 is misaligned. A word access with addr[1:0]!=0 is misaligned.
- IDLE transitions on accept:
  - nop or misaligned -> RESP, no bus request.
  - Any other operation -> REQ.
- REQ:
  - o_mem_req=1. we/addr/be/wdata are held stable until ack.
  - i_mem_ack=1 -> capture the extended read data, go to RESP.
- RESP: o_valid=1 for exactly one cycle, then IDLE. o_misaligned and o_fault are valid only while o_valid=1.
- i_mem_ack outside REQ is ignored.
- Byte enables (o = addr[1:0]):
  - Byte access: be = 4'b0001<<o; wdata = {4{wdata[7:0]}}.
  - Halfword access: be = 4'b0011<<o; wdata = {2{wdata[15:0]}}.
  - Word access: be = 4'b1111; wdata unchanged.
  - Loads drive be with the same pattern and o_mem_we=0.
- Load extraction:
  - Byte: lane = rdata[8*o +: 8].
  - Halfword: lane = rdata[16*o[1] +: 16].
  - l_byte and l_hword sign-extend; l_ubyte and l_uhword zero-extend; l_word passes through.
- Latency from accept edge:
  - Bus op: o_mem_req on the next cycle. o_valid one cycle after the ack cycle; minimum is 2 cycles if ack arrives in the first REQ cycle.
  - nop or misaligned: o_valid on the next cycle.
- Throughput: a new request may be accepted in the cycle after RESP. Back-to-back peak rate is one operation per 3 cycles.

Optional Feature:
LSU_BUS_TIMEOUT_EN.
- Defined:
  - An 8..32-bit counter (sized by $clog2(TIMEOUT_CYCLES+1)) clears on entry to REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES with no ack: drop o_mem_req and go to RESP with o_fault=1, o_rdata=0.
  - An ack in the same cycle as the limit wins over the timeout.
- Undefined: no counter; REQ waits indefinitely; o_fault tied 0.

Test Plan:
- l_byte, addr=0x1003, bus word 0x80FF_1234, ack in first REQ cycle -> be=4'b1000, o_rdata=0xFFFF_FF80, o_valid 2 cycles after accept.
- l_uhword, addr=0x2002, rdata=0xBEEF_0000, ack after 5 wait cycles -> o_mem_req held 6 cycles with stable addr 0x2000, o_rdata=0x0000_BEEF.
- s_hword, addr=0x10, wdata=0x1234_ABCD -> we=1, be=4'b0011, o_mem_wdata=0xABCD_ABCD, o_rdata=0.
- l_word, addr=0x6 -> no o_mem_req, o_valid with o_misaligned=1 one cycle after accept, o_rdata=0. memop_nop -> o_valid, no bus access.
- i_rst pulsed mid-REQ (no ack) -> o_mem_req falls asynchronously, o_ready=1, no o_valid. A subsequent s_word to 0x40 completes normally.
- With LSU_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, never ack -> o_mem_req high exactly 4 cycles, then o_valid with o_fault=1.
